// File: rtl/pfpu_seq_if.sv
// pfpu_seq_if: program-memory and register-file/ALU port bundle of the PFPU
// program sequencer.
//
//   pm_a    seq -> pm    program memory read address (synchronous RAM)
//   pm_d    pm  -> seq   instruction word, valid one cycle after pm_a
//   a_addr  seq -> rf    register-file read address, operand A
//   b_addr  seq -> rf    register-file read address, operand B
//   alu_op  seq -> alu   opcode aligned with the register-file read data
//   w_addr  seq -> rf    write-back register address
//   w_en    seq -> rf    write-back strobe
//
// The sequencer is the master. None of these signals has a ready: the
// program memory and register file always accept, and every valid/strobe
// means "this cycle's data is meaningful" and carries no backpressure.
interface pfpu_seq_if #(
    parameter int PC_W = 11
);
    logic [PC_W-1:0] pm_a;
    logic [24:0]     pm_d;
    logic [6:0]      a_addr;
    logic [6:0]      b_addr;
    logic [3:0]      alu_op;
    logic [6:0]      w_addr;
    logic            w_en;

    modport master (
        output pm_a, a_addr, b_addr, alu_op, w_addr, w_en,
        input  pm_d
    );

    modport slave (
        input  pm_a, a_addr, b_addr, alu_op, w_addr, w_en,
        output pm_d
    );
endinterface

// File: rtl/pfpu_seq.sv
// pfpu_seq: PFPU program sequencer. Fetches one instruction per cycle for a
// vertex pass, drives register-file read addresses and the ALU opcode, and
// schedules each result's write-back through an 8-slot delay line indexed by
// the opcode latency.
//
// Ports:
//   sys_clk        system clock
//   sys_rst        synchronous reset, active-high
//   start          begin a vertex pass (honoured only when idle)
//   last_pc        address of the last instruction, sampled on start
//   busy           high while fetching or draining
//   vertex_done    one-cycle pulse at the end of a pass
//   err_collision  sticky write-back collision flag
//   dbg_state      current FSM state (IDLE=0, FETCH=1, DRAIN=2)
//   bus            pfpu_seq_if master: pm_a/pm_d, a_addr/b_addr, alu_op,
//                  w_addr/w_en
//
// Build option:
//   PFPU_COLLISION_DETECT_EN  when defined, a write-back landing on an
//   occupied delay-line slot sets err_collision (cleared by the next accepted
//   start). When undefined, err_collision is tied to 0. In both builds the
//   later instruction overwrites the slot.
module pfpu_seq #(
    parameter int PC_W = 11
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            start,
    input  logic [PC_W-1:0] last_pc,
    output logic            busy,
    output logic            vertex_done,
    output logic            err_collision,
    output logic [1:0]      dbg_state,
    pfpu_seq_if.master      bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic            vertex_done_q, vertex_done_d;
    logic            issue_v_q;
    logic [3:0]      alu_op_q;

    // Write-back delay line: slot 0 is the one being written this cycle.
    logic [7:0]      slot_v_q, slot_v_d;
    logic [6:0]      slot_a_q [8];
    logic [6:0]      slot_a_d [8];

    logic [3:0]      op_dec;
    logic [2:0]      lat;

    // Cycles from issue to write-back; 0 means the opcode writes nothing.
    function automatic logic [2:0] latency(input logic [3:0] op);
        case (op)
            4'd0:       latency = 3'd0;   // NOP
            4'd1, 4'd2: latency = 3'd5;   // FADD, FSUB
            4'd3:       latency = 3'd7;   // FMUL
            4'd4, 4'd5: latency = 3'd2;   // FABS, F2I
            4'd6:       latency = 3'd3;   // I2F
            4'd7:       latency = 3'd0;   // VECTOUT
            default:    latency = 3'd1;
        endcase
    endfunction

    // The instruction word is only meaningful the cycle after a fetch;
    // otherwise the decode sees a NOP.
    assign op_dec = issue_v_q ? bus.pm_d[24:21] : 4'd0;
    assign lat    = latency(op_dec);

    assign bus.a_addr = issue_v_q ? bus.pm_d[20:14] : 7'd0;
    assign bus.b_addr = issue_v_q ? bus.pm_d[13:7]  : 7'd0;
    assign bus.pm_a   = (state_q == S_FETCH) ? pc_q : '0;
    assign bus.alu_op = alu_op_q;
    assign bus.w_addr = slot_a_q[0];
    // Gated by reset so no write escapes in the cycle reset is sampled.
    assign bus.w_en   = slot_v_q[0] & ~sys_rst;

    assign busy        = (state_q != S_IDLE);
    assign vertex_done = vertex_done_q;
    assign dbg_state   = state_q;

`ifdef PFPU_COLLISION_DETECT_EN
    logic coll_hit;
    logic err_q, err_d;
    assign err_collision = err_q;
`else
    assign err_collision = 1'b0;
`endif

    // Delay line: shift toward slot 0, then drop the issued entry at slot L.
    // Inserting after the shift means an entry placed at slot L reaches
    // slot 0 exactly L cycles later.
    always_comb begin
        slot_v_d = {1'b0, slot_v_q[7:1]};
        for (int i = 0; i < 7; i++) begin
            slot_a_d[i] = slot_a_q[i+1];
        end
        slot_a_d[7] = 7'd0;
`ifdef PFPU_COLLISION_DETECT_EN
        coll_hit = 1'b0;
`endif
        if (lat != 3'd0) begin
`ifdef PFPU_COLLISION_DETECT_EN
            coll_hit = slot_v_d[lat];
`endif
            slot_v_d[lat] = 1'b1;
            slot_a_d[lat] = bus.pm_d[6:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        last_pc_d     = last_pc_q;
        vertex_done_d = 1'b0;
`ifdef PFPU_COLLISION_DETECT_EN
        err_d         = err_q | coll_hit;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d      = '0;
                    last_pc_d = last_pc;
                    state_d   = S_FETCH;
`ifdef PFPU_COLLISION_DETECT_EN
                    err_d     = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                if (pc_q == last_pc_q) begin
                    state_d = S_DRAIN;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // vertex_done is registered, so look at the next line
                // contents: the pass ends once nothing is left to write,
                // including anything the final issue would have inserted.
                if (slot_v_d == 8'd0) begin
                    state_d       = S_IDLE;
                    vertex_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            last_pc_q     <= '0;
            vertex_done_q <= 1'b0;
            issue_v_q     <= 1'b0;
            alu_op_q      <= 4'd0;
            slot_v_q      <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                slot_a_q[i] <= 7'd0;
            end
`ifdef PFPU_COLLISION_DETECT_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            last_pc_q     <= last_pc_d;
            vertex_done_q <= vertex_done_d;
            issue_v_q     <= (state_q == S_FETCH);
            alu_op_q      <= op_dec;
            slot_v_q      <= slot_v_d;
            for (int i = 0; i < 8; i++) begin
                slot_a_q[i] <= slot_a_d[i];
            end
`ifdef PFPU_COLLISION_DETECT_EN
            err_q         <= err_d;
`endif
        end
    end

endmodule
